// File: rtl/fpu_pipe_ctl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fpu_pipe_ctl_if                                                 |
// | Purpose  : ID-stage issue inputs and E1..WB tracking outputs of the FP      |
// |            pipeline control block                                          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface fpu_pipe_ctl_if;
  logic [4:0]  fd;
  logic [2:0]  fc;
  logic        wf;
  logic        fasmds;
  logic        stall_lw;
  logic        stall_fp;
  logic        stall_lwc1;
  logic        stall_swc1;
  logic [4:0]  e1n;
  logic [4:0]  e2n;
  logic [4:0]  e3n;
  logic        e1w;
  logic        e2w;
  logic        e3w;
  logic [2:0]  e1c;
  logic [4:0]  wn;
  logic        ww;
  logic        st;
  logic        stall;
  logic [31:0] cnt_issue;
  logic [31:0] cnt_st;

  // master: integer-unit side; slave: the FP pipeline control
  modport master (
    output fd, fc, wf, fasmds, stall_lw, stall_fp, stall_lwc1, stall_swc1,
    input  e1n, e2n, e3n, e1w, e2w, e3w, e1c, wn, ww, st, stall, cnt_issue, cnt_st
  );

  modport slave (
    input  fd, fc, wf, fasmds, stall_lw, stall_fp, stall_lwc1, stall_swc1,
    output e1n, e2n, e3n, e1w, e2w, e3w, e1c, wn, ww, st, stall, cnt_issue, cnt_st
  );
endinterface
`default_nettype wire

// File: rtl/fpu_pipe_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fpu_pipe_ctl                                                    |
// | Purpose  : FP pipeline destination tracking E1/E2/E3/WB, iterative          |
// |            div/sqrt sequencing and stall combination.                      |
// |            Optional macro FPU_PERF_CNT_EN adds issue / st-cycle counters.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fpu_pipe_ctl #(
  parameter int unsigned ITER_CYCLES = 12
) (
  input  logic           clk,
  input  logic           clr,
  fpu_pipe_ctl_if.slave  bus
);

  localparam logic [5:0] C_ITER_LAST = 6'(ITER_CYCLES - 1);

  logic [4:0] r_e1n, r_e2n, r_e3n, r_wn;
  logic       r_e1w, r_e2w, r_e3w, r_ww;
  logic [2:0] r_e1c;
  logic [5:0] r_cnt;

  logic       w_st;
  logic       w_stall;
  logic       w_issue;

  assign w_st    = (r_cnt != 6'd0);
  assign w_stall = bus.stall_lw | bus.stall_fp | bus.stall_lwc1 | bus.stall_swc1 | w_st;
  assign w_issue = bus.fasmds & bus.wf & ~w_stall;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_e1n <= '0;
      r_e1w <= 1'b0;
      r_e1c <= '0;
      r_e2n <= '0;
      r_e2w <= 1'b0;
      r_e3n <= '0;
      r_e3w <= 1'b0;
      r_wn  <= '0;
      r_ww  <= 1'b0;
      r_cnt <= '0;
    end else begin
      // E3 and WB always drain, even while E1 iterates
      r_e3n <= r_e2n;
      r_e3w <= r_e2w;
      r_wn  <= r_e3n;
      r_ww  <= r_e3w;
      if (w_st) begin
        r_cnt <= r_cnt - 6'd1;
        r_e2n <= '0;
        r_e2w <= 1'b0;
      end else begin
        r_e2n <= r_e1n;
        r_e2w <= r_e1w;
        if (w_issue) begin
          r_e1n <= bus.fd;
          r_e1w <= 1'b1;
          r_e1c <= bus.fc;
          r_cnt <= bus.fc[2] ? C_ITER_LAST : 6'd0;
        end else begin
          r_e1n <= '0;
          r_e1w <= 1'b0;
          r_e1c <= '0;
        end
      end
    end
  end

  assign bus.e1n   = r_e1n;
  assign bus.e2n   = r_e2n;
  assign bus.e3n   = r_e3n;
  assign bus.e1w   = r_e1w;
  assign bus.e2w   = r_e2w;
  assign bus.e3w   = r_e3w;
  assign bus.e1c   = r_e1c;
  assign bus.wn    = r_wn;
  assign bus.ww    = r_ww;
  assign bus.st    = w_st;
  assign bus.stall = w_stall;

`ifdef FPU_PERF_CNT_EN
  logic [31:0] r_cnt_issue;
  logic [31:0] r_cnt_st;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt_issue <= '0;
      r_cnt_st    <= '0;
    end else begin
      if (w_issue) r_cnt_issue <= r_cnt_issue + 32'd1;
      if (w_st)    r_cnt_st    <= r_cnt_st + 32'd1;
    end
  end

  assign bus.cnt_issue = r_cnt_issue;
  assign bus.cnt_st    = r_cnt_st;
`else
  assign bus.cnt_issue = '0;
  assign bus.cnt_st    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpu_pipe_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fpu_pipe_ctl                                                 |
// | Purpose  : bench for fpu_pipe_ctl; timeline model of per-op stage          |
// |            occupancy plus directed literal checks (FPU_PERF_CNT_EN aware)  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fpu_pipe_ctl;

  localparam int ITER = 12;
  localparam int N    = 4096;

  logic clk;
  logic clr;
  fpu_pipe_ctl_if bus ();

  fpu_pipe_ctl #(.ITER_CYCLES(ITER)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Model: each issued op is placed on a per-cycle timeline of stage occupancy
  logic [4:0]  m_e1n [N];
  logic [4:0]  m_e2n [N];
  logic [4:0]  m_e3n [N];
  logic [4:0]  m_wn  [N];
  logic [2:0]  m_e1c [N];
  logic        m_e1w [N];
  logic        m_e2w [N];
  logic        m_e3w [N];
  logic        m_ww  [N];
  logic        m_st  [N];
  logic [31:0] m_cnt_issue;
  logic [31:0] m_cnt_st;
  int          cyc = 0;

  task automatic schedule(input int t, input logic [4:0] d, input logic [2:0] c);
    int h;
    h = c[2] ? ITER - 1 : 0;
    if (t + 4 + h < N) begin
      for (int k = 1; k <= 1 + h; k++) begin
        m_e1n[t+k] = d; m_e1w[t+k] = 1'b1; m_e1c[t+k] = c;
      end
      for (int k = 1; k <= h; k++) m_st[t+k] = 1'b1;
      m_e2n[t+2+h] = d; m_e2w[t+2+h] = 1'b1;
      m_e3n[t+3+h] = d; m_e3w[t+3+h] = 1'b1;
      m_wn [t+4+h] = d; m_ww [t+4+h] = 1'b1;
    end
  endtask

  // Compare process: checks every cycle on the falling edge, then advances the model
  initial begin
    logic stall_m;
    forever begin
      @(negedge clk);
      if (clr) begin
        for (int i = cyc; i < N; i++) begin
          m_e1n[i] = '0; m_e2n[i] = '0; m_e3n[i] = '0; m_wn[i] = '0; m_e1c[i] = '0;
          m_e1w[i] = 1'b0; m_e2w[i] = 1'b0; m_e3w[i] = 1'b0; m_ww[i] = 1'b0; m_st[i] = 1'b0;
        end
        m_cnt_issue = '0;
        m_cnt_st    = '0;
      end else begin
        chk("e1n", 32'(bus.e1n), 32'(m_e1n[cyc]));
        chk("e1w", 32'(bus.e1w), 32'(m_e1w[cyc]));
        chk("e1c", 32'(bus.e1c), 32'(m_e1c[cyc]));
        chk("e2n", 32'(bus.e2n), 32'(m_e2n[cyc]));
        chk("e2w", 32'(bus.e2w), 32'(m_e2w[cyc]));
        chk("e3n", 32'(bus.e3n), 32'(m_e3n[cyc]));
        chk("e3w", 32'(bus.e3w), 32'(m_e3w[cyc]));
        chk("wn",  32'(bus.wn),  32'(m_wn[cyc]));
        chk("ww",  32'(bus.ww),  32'(m_ww[cyc]));
        chk("st",  32'(bus.st),  32'(m_st[cyc]));
        stall_m = bus.stall_lw | bus.stall_fp | bus.stall_lwc1 | bus.stall_swc1 | m_st[cyc];
        chk("stall", 32'(bus.stall), 32'(stall_m));
`ifdef FPU_PERF_CNT_EN
        chk("cnt_issue", bus.cnt_issue, m_cnt_issue);
        chk("cnt_st",    bus.cnt_st,    m_cnt_st);
`else
        chk("cnt_issue", bus.cnt_issue, 32'd0);
        chk("cnt_st",    bus.cnt_st,    32'd0);
`endif
        if (m_st[cyc]) m_cnt_st = m_cnt_st + 32'd1;
      end
      stall_m = bus.stall_lw | bus.stall_fp | bus.stall_lwc1 | bus.stall_swc1 | m_st[cyc];
      if (bus.fasmds && bus.wf && !stall_m) begin
        schedule(cyc, bus.fd, bus.fc);
        m_cnt_issue = m_cnt_issue + 32'd1;
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic w, input logic [4:0] d, input logic [2:0] c);
    bus.fasmds = v; bus.wf = w; bus.fd = d; bus.fc = c;
  endtask

  task automatic idle();
    put(1'b0, 1'b0, 5'd0, 3'd0);
    bus.stall_lw = 1'b0; bus.stall_fp = 1'b0; bus.stall_lwc1 = 1'b0; bus.stall_swc1 = 1'b0;
  endtask

  initial begin
    logic [2:0] ops [5];
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b100; ops[4] = 3'b101;
    clr = 1'b1;
    idle();
    step(); step();
    @(negedge clk); #2 clr = 1'b0;

    // single add fd=5: one cycle in each stage, write 4 cycles after issue
    step(); put(1'b1, 1'b1, 5'd5, 3'b000);
    #1 chk("reset_ww", 32'(bus.ww), 32'd0);
    step(); idle(); #1 chk("add_e1n", 32'(bus.e1n), 32'd5); chk("add_e1w", 32'(bus.e1w), 32'd1);
    step(); #1 chk("add_e2n", 32'(bus.e2n), 32'd5); chk("add_e1w_gone", 32'(bus.e1w), 32'd0);
    step(); #1 chk("add_e3n", 32'(bus.e3n), 32'd5);
    step(); #1 chk("add_ww", 32'(bus.ww), 32'd1); chk("add_wn", 32'(bus.wn), 32'd5);
    step(); #1 chk("add_ww_once", 32'(bus.ww), 32'd0);

    // back-to-back muls
    step(); put(1'b1, 1'b1, 5'd1, 3'b010);
    step(); put(1'b1, 1'b1, 5'd2, 3'b010);
    step(); put(1'b1, 1'b1, 5'd3, 3'b010);
    step(); idle(); #1
    chk("mul_e1n", 32'(bus.e1n), 32'd3); chk("mul_e2n", 32'(bus.e2n), 32'd2);
    chk("mul_e3n", 32'(bus.e3n), 32'd1);
    step(); #1 chk("mul_wn1", 32'({bus.ww, bus.wn}), 32'h21);
    step(); #1 chk("mul_wn2", 32'({bus.ww, bus.wn}), 32'h22);
    step(); #1 chk("mul_wn3", 32'({bus.ww, bus.wn}), 32'h23);
    step(); #1 chk("mul_ww_end", 32'(bus.ww), 32'd0);

    // div fd=7: 11 st cycles, write at issue+15
    step(); put(1'b1, 1'b1, 5'd7, 3'b100);
    step(); idle(); #1
    chk("div_st_first", 32'(bus.st), 32'd1); chk("div_stall", 32'(bus.stall), 32'd1);
    chk("div_e2w", 32'(bus.e2w), 32'd0);
    repeat (10) step();
    #1 chk("div_st_last", 32'(bus.st), 32'd1);
    step(); #1 chk("div_st_drop", 32'(bus.st), 32'd0); chk("div_e1n_held", 32'(bus.e1n), 32'd7);
    step(); #1 chk("div_e2n", 32'(bus.e2n), 32'd7);
    step(); #1 chk("div_ww_early", 32'(bus.ww), 32'd0);
    step(); #1 chk("div_wb", 32'({bus.ww, bus.wn}), 32'h27);

    // load-use stall blocks issue for one cycle
    step(); put(1'b1, 1'b1, 5'd9, 3'b001); bus.stall_lw = 1'b1;
    #1 chk("lw_stall", 32'(bus.stall), 32'd1);
    step(); bus.stall_lw = 1'b0; #1 chk("lw_no_issue", 32'(bus.e1w), 32'd0);
    step(); idle(); #1 chk("lw_issue_w", 32'(bus.e1w), 32'd1); chk("lw_issue_n", 32'(bus.e1n), 32'd9);
    repeat (6) step();

    // asynchronous reset in the middle of a div
    step(); put(1'b1, 1'b1, 5'd4, 3'b101);
    step(); idle();
    repeat (3) step();
    #1 chk("rst_pre_st", 32'(bus.st), 32'd1);
    #1 clr = 1'b1;
    #1 chk("rst_st", 32'(bus.st), 32'd0); chk("rst_e1w", 32'(bus.e1w), 32'd0);
    chk("rst_ww", 32'(bus.ww), 32'd0); chk("rst_stall", 32'(bus.stall), 32'd0);
    @(negedge clk); #2 clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(); #1 chk("rst_no_write", 32'(bus.ww), 32'd0);
    end

    // counters after reset: add, div, sub
    step(); put(1'b1, 1'b1, 5'd1, 3'b000);
    step(); put(1'b1, 1'b1, 5'd2, 3'b100);
    step(); idle();
    repeat (10) step();
    step(); put(1'b1, 1'b1, 5'd3, 3'b001);
    step(); idle(); #1
`ifdef FPU_PERF_CNT_EN
    chk("perf_issue", bus.cnt_issue, 32'd3); chk("perf_st", bus.cnt_st, 32'd11);
`else
    chk("perf_issue_off", bus.cnt_issue, 32'd0); chk("perf_st_off", bus.cnt_st, 32'd0);
`endif

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step();
      bus.fasmds     = ($urandom_range(0, 9) < 7);
      bus.wf         = ($urandom_range(0, 9) < 8);
      bus.fd         = 5'($urandom);
      bus.fc         = ops[$urandom_range(0, 4)];
      bus.stall_lw   = ($urandom_range(0, 9) == 0);
      bus.stall_fp   = ($urandom_range(0, 9) == 0);
      bus.stall_lwc1 = ($urandom_range(0, 19) == 0);
      bus.stall_swc1 = ($urandom_range(0, 19) == 0);
    end
    step(); idle();
    repeat (20) step();
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
